sdram_arbit: RTL and testbench

- Top-level arbiter/sequencer for the SDRAM controller. It owns the SDRAM command/address pins and grants them to one engine at a time: the init, auto-refresh, write and read engines.
- Holds the INIT state until init completes. It then grants refresh, write and read by fixed priority, issuing a one-cycle enable to the winner.
- It muxes the winner's command, bank and address onto the chip and returns to IDLE on that engine's end flag.

---
 rtl/sdram_pkg.sv | 32 +++
 rtl/sdram_arbit.sv | 196 +++++++++++++++++++
 tb/tb_sdram_arbit.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_pkg
//  Description : Shared definitions for the SDRAM controller: arbiter state
//                encoding and chip command encodings {cs_n,ras_n,cas_n,we_n}.
//  Revision    : 1.0 - initial release
// ============================================================================
package sdram_pkg;

  // Arbiter state encoding; kept as plain localparams so engines can compare
  // against them without depending on the enum type.
  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_AREF  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_READ  = 3'd4;

  typedef enum logic [2:0] {
    S_INIT  = ST_INIT,
    S_IDLE  = ST_IDLE,
    S_AREF  = ST_AREF,
    S_WRITE = ST_WRITE,
    S_READ  = ST_READ
  } arb_state_e;

  // Chip command encodings {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;

endpackage : sdram_pkg
`default_nettype wire

// File: rtl/sdram_arbit.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_arbit
//  Description : SDRAM command-bus arbiter. Holds INIT until the init engine
//                finishes, then grants refresh > write > read with a one-cycle
//                enable pulse and muxes the winner's command/address/bank onto
//                the chip pins until that engine's end flag.
//                Optional macro SDRAM_ARB_RR_EN: write/read ties alternate
//                round-robin instead of fixed write-first priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_arbit #(
  parameter int          ADDR_W  = 13,
  parameter int          BA_W    = 2,
  parameter logic [3:0]  CMD_NOP = 4'b0111
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  // init engine
  input  logic              flag_init_end,
  input  logic [3:0]        init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  // auto-refresh engine
  input  logic              ref_req,
  output logic              ref_en,
  input  logic              flag_ref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [ADDR_W-1:0] aref_addr,
  // write engine
  input  logic              wr_req,
  output logic              wr_en,
  input  logic              flag_wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BA_W-1:0]   wr_bank,
  // read engine
  input  logic              rd_req,
  output logic              rd_en,
  input  logic              flag_rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [BA_W-1:0]   rd_bank,
  // chip side
  output logic              ref_pending,
  output logic [3:0]        sdram_cmd,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [BA_W-1:0]   sdram_bank,
  output logic              dq_oe
);

  import sdram_pkg::*;

  arb_state_e state_q, state_d;
  logic       ref_en_q, ref_en_d;
  logic       wr_en_q,  wr_en_d;
  logic       rd_en_q,  rd_en_d;

  // High when READ was the most recent write/read grant, so a tie goes to WRITE.
  logic       last_rd_w;

  // Picks the next burst owner from IDLE. Refresh always wins; a write/read
  // tie goes to whichever was not granted last.
  function automatic arb_state_e pick_next(input logic req_ref,
                                           input logic req_wr,
                                           input logic req_rd,
                                           input logic last_rd);
    arb_state_e nxt;
    nxt = S_IDLE;
    if (req_ref)
      nxt = S_AREF;
    else if (req_wr && req_rd)
      nxt = last_rd ? S_WRITE : S_READ;
    else if (req_wr)
      nxt = S_WRITE;
    else if (req_rd)
      nxt = S_READ;
    return nxt;
  endfunction

`ifdef SDRAM_ARB_RR_EN
  logic last_rd_q, last_rd_d;

  // Remember which of write/read was granted last.
  always_comb begin
    last_rd_d = last_rd_q;
    if (wr_en_d)
      last_rd_d = 1'b0;
    else if (rd_en_d)
      last_rd_d = 1'b1;
  end

  // Round-robin history register; reset as if READ went last.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n)
      last_rd_q <= 1'b1;
    else
      last_rd_q <= last_rd_d;
  end

  assign last_rd_w = last_rd_q;
`else
  assign last_rd_w = 1'b1;
`endif

  // State and grant-pulse registers.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q  <= S_INIT;
      ref_en_q <= 1'b0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ref_en_q <= ref_en_d;
      wr_en_q  <= wr_en_d;
      rd_en_q  <= rd_en_d;
    end
  end

  // Next-state logic; an enable fires only on the IDLE -> burst transition.
  always_comb begin
    state_d  = state_q;
    ref_en_d = 1'b0;
    wr_en_d  = 1'b0;
    rd_en_d  = 1'b0;
    case (state_q)
      S_INIT: begin
        if (flag_init_end)
          state_d = S_IDLE;
      end
      S_IDLE: begin
        state_d  = pick_next(ref_req, wr_req, rd_req, last_rd_w);
        ref_en_d = (state_d == S_AREF);
        wr_en_d  = (state_d == S_WRITE);
        rd_en_d  = (state_d == S_READ);
      end
      S_AREF: begin
        if (flag_ref_end)
          state_d = S_IDLE;
      end
      S_WRITE: begin
        if (flag_wr_end)
          state_d = S_IDLE;
      end
      S_READ: begin
        if (flag_rd_end)
          state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  // Chip pin mux; forced to idle values while reset is held so the pins are
  // quiet even before the first clock edge.
  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_addr = '0;
    sdram_bank = '0;
    if (s_rst_n) begin
      case (state_q)
        S_INIT: begin
          sdram_cmd  = init_cmd;
          sdram_addr = init_addr;
        end
        S_AREF: begin
          sdram_cmd  = aref_cmd;
          sdram_addr = aref_addr;
        end
        S_WRITE: begin
          sdram_cmd  = wr_cmd;
          sdram_addr = wr_addr;
          sdram_bank = wr_bank;
        end
        S_READ: begin
          sdram_cmd  = rd_cmd;
          sdram_addr = rd_addr;
          sdram_bank = rd_bank;
        end
        default: begin
          sdram_cmd  = CMD_NOP;
          sdram_addr = '0;
          sdram_bank = '0;
        end
      endcase
    end
  end

  assign ref_en      = ref_en_q;
  assign wr_en       = wr_en_q;
  assign rd_en       = rd_en_q;
  // Lets the active data engine cut its burst short so refresh gets in.
  assign ref_pending = ref_req && ((state_q == S_WRITE) || (state_q == S_READ));
  assign dq_oe       = (state_q == S_WRITE);

endmodule : sdram_arbit
`default_nettype wire

// File: tb/tb_sdram_arbit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_arbit
//  Description : Self-checking bench for sdram_arbit. Expected grants are
//                queued when requests are driven and popped when an enable
//                pulse appears; pin-mux values are checked directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_arbit;

  localparam int AW = 13;
  localparam int BW = 2;

  localparam int G_NONE = 0;
  localparam int G_REF  = 1;
  localparam int G_WR   = 2;
  localparam int G_RD   = 3;
  localparam int G_MULT = 7;

  localparam logic [3:0]    NOP      = 4'b0111;
  localparam logic [3:0]    C_INIT   = 4'b0010;
  localparam logic [3:0]    C_AREF   = 4'b0001;
  localparam logic [3:0]    C_WR     = 4'b0100;
  localparam logic [3:0]    C_RD     = 4'b0101;
  localparam logic [AW-1:0] A_INIT   = 13'h0400;
  localparam logic [AW-1:0] A_AREF   = 13'h0011;
  localparam logic [AW-1:0] A_WR     = 13'h0123;
  localparam logic [AW-1:0] A_RD     = 13'h0456;
  localparam logic [BW-1:0] B_WR     = 2'd2;
  localparam logic [BW-1:0] B_RD     = 2'd1;

  logic          sclk = 1'b0;
  logic          s_rst_n;
  logic          flag_init_end;
  logic [3:0]    init_cmd;
  logic [AW-1:0] init_addr;
  logic          ref_req, ref_en, flag_ref_end;
  logic [3:0]    aref_cmd;
  logic [AW-1:0] aref_addr;
  logic          wr_req, wr_en, flag_wr_end;
  logic [3:0]    wr_cmd;
  logic [AW-1:0] wr_addr;
  logic [BW-1:0] wr_bank;
  logic          rd_req, rd_en, flag_rd_end;
  logic [3:0]    rd_cmd;
  logic [AW-1:0] rd_addr;
  logic [BW-1:0] rd_bank;
  logic          ref_pending;
  logic [3:0]    sdram_cmd;
  logic [AW-1:0] sdram_addr;
  logic [BW-1:0] sdram_bank;
  logic          dq_oe;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int exp_q[$];

  always #5 sclk = ~sclk;

  sdram_arbit #(.ADDR_W(AW), .BA_W(BW), .CMD_NOP(NOP)) dut (
    .sclk(sclk), .s_rst_n(s_rst_n),
    .flag_init_end(flag_init_end), .init_cmd(init_cmd), .init_addr(init_addr),
    .ref_req(ref_req), .ref_en(ref_en), .flag_ref_end(flag_ref_end),
    .aref_cmd(aref_cmd), .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_en(wr_en), .flag_wr_end(flag_wr_end),
    .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank),
    .rd_req(rd_req), .rd_en(rd_en), .flag_rd_end(flag_rd_end),
    .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
    .ref_pending(ref_pending), .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr),
    .sdram_bank(sdram_bank), .dq_oe(dq_oe)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  function automatic int grant_code();
    int c;
    c = G_NONE;
    if ((ref_en + wr_en + rd_en) > 1) c = G_MULT;
    else if (ref_en === 1'b1)        c = G_REF;
    else if (wr_en === 1'b1)         c = G_WR;
    else if (rd_en === 1'b1)         c = G_RD;
    return c;
  endfunction

  // Waits (bounded) for the next enable pulse, pops the expected grant and
  // compares; exp_cyc > 0 also checks how many edges it took.
  task automatic await_grant(input string tag, input int max_cyc, input int exp_cyc,
                             output int got);
    int cyc;
    int want;
    cyc = 0;
    got = G_NONE;
    while (got == G_NONE && cyc < max_cyc) begin
      tick();
      cyc++;
      got = grant_code();
    end
    if (exp_q.size() == 0) want = -1;
    else want = exp_q.pop_front();
    chk({tag, " grant"}, got, want);
    if (exp_cyc > 0) chk({tag, " latency"}, cyc, exp_cyc);
  endtask

  // One-cycle end-flag pulse; returns positioned in the following cycle.
  task automatic pulse_end(input int which);
    if (which == G_REF) flag_ref_end = 1'b1;
    if (which == G_WR)  flag_wr_end  = 1'b1;
    if (which == G_RD)  flag_rd_end  = 1'b1;
    tick();
    flag_ref_end = 1'b0;
    flag_wr_end  = 1'b0;
    flag_rd_end  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g;
    int bad;
    s_rst_n = 1'b1;
    flag_init_end = 1'b0;
    init_cmd = C_INIT;  init_addr = A_INIT;
    aref_cmd = C_AREF;  aref_addr = A_AREF;
    wr_cmd = C_WR; wr_addr = A_WR; wr_bank = B_WR;
    rd_cmd = C_RD; rd_addr = A_RD; rd_bank = B_RD;
    ref_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    flag_ref_end = 1'b0; flag_wr_end = 1'b0; flag_rd_end = 1'b0;

    // ---------------- reset values ----------------
    #1 s_rst_n = 1'b0;
    #1;
    chk("rst cmd",   sdram_cmd, NOP);
    chk("rst addr",  sdram_addr, 0);
    chk("rst bank",  sdram_bank, 0);
    chk("rst en",    {ref_en, wr_en, rd_en}, 3'b000);
    chk("rst dq_oe", dq_oe, 1'b0);
    chk("rst refp",  ref_pending, 1'b0);
    tick(); tick();
    s_rst_n = 1'b1;
    ref_req = 1'b1;   // requests during INIT must not be granted
    wr_req  = 1'b1;

    // ---------------- INIT hold for 100 cycles ----------------
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (sdram_cmd !== C_INIT || sdram_addr !== A_INIT || sdram_bank !== 0 ||
          {ref_en, wr_en, rd_en} !== 3'b000 || dq_oe !== 1'b0)
        bad++;
    end
    chk("init hold bad cycles", bad, 0);
    chk("init cmd", sdram_cmd, C_INIT);
    ref_req = 1'b0;
    wr_req  = 1'b0;
    flag_init_end = 1'b1;
    tick();
    chk("idle cmd",  sdram_cmd, NOP);
    chk("idle addr", sdram_addr, 0);
    chk("idle en",   {ref_en, wr_en, rd_en}, 3'b000);

    // ---------------- simultaneous requests ----------------
    ref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    exp_q.push_back(G_REF);
    exp_q.push_back(G_WR);
    await_grant("tie ref", 4, 1, g);
    chk("aref cmd",  sdram_cmd, C_AREF);
    chk("aref addr", sdram_addr, A_AREF);
    chk("aref bank", sdram_bank, 0);
    ref_req = 1'b0;
    tick();
    chk("ref_en one cycle", ref_en, 1'b0);
    chk("aref held", sdram_cmd, C_AREF);
    pulse_end(G_REF);
    chk("idle gap cmd", sdram_cmd, NOP);
    chk("idle gap wr_en", wr_en, 1'b0);
    await_grant("wr after ref", 4, 1, g);
    chk("wr cmd",   sdram_cmd, C_WR);
    chk("wr addr",  sdram_addr, A_WR);
    chk("wr bank",  sdram_bank, B_WR);
    chk("wr dq_oe", dq_oe, 1'b1);
    wr_req = 1'b0;

    // ---------------- refresh arriving mid-write ----------------
    ref_req = 1'b1;
    exp_q.push_back(G_REF);
    exp_q.push_back(G_RD);
    #1;
    chk("ref_pending in write", ref_pending, 1'b1);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ref_en !== 1'b0 || rd_en !== 1'b0 || dq_oe !== 1'b1 || ref_pending !== 1'b1)
        bad++;
    end
    chk("write not preempted", bad, 0);
    pulse_end(G_WR);
    chk("idle after wr ref_en", ref_en, 1'b0);
    chk("idle ref_pending", ref_pending, 1'b0);
    await_grant("ref after wr", 4, 1, g);
    ref_req = 1'b0;
    pulse_end(G_REF);
    await_grant("rd after ref", 4, 1, g);
    chk("rd cmd",  sdram_cmd, C_RD);
    chk("rd addr", sdram_addr, A_RD);
    chk("rd bank", sdram_bank, B_RD);
    rd_req = 1'b0;

    // ---------------- foreign end flags ignored in READ ----------------
    flag_wr_end = 1'b1;
    flag_ref_end = 1'b1;
    flag_init_end = 1'b0;
    tick();
    flag_wr_end = 1'b0;
    flag_ref_end = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (sdram_cmd !== C_RD || dq_oe !== 1'b0 || {ref_en, wr_en, rd_en} !== 3'b000)
        bad++;
      tick();
    end
    chk("read holds", bad, 0);
    pulse_end(G_RD);
    chk("idle after rd", sdram_cmd, NOP);

    // ---------------- write/read tie sequence ----------------
`ifdef SDRAM_ARB_RR_EN
    exp_q.push_back(G_WR); exp_q.push_back(G_RD);
    exp_q.push_back(G_WR); exp_q.push_back(G_RD);
`else
    exp_q.push_back(G_WR); exp_q.push_back(G_WR);
    exp_q.push_back(G_WR); exp_q.push_back(G_WR);
`endif
    wr_req = 1'b1;
    rd_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      await_grant($sformatf("tie wr/rd #%0d", k), 4, 1, g);
      pulse_end((g == G_RD) ? G_RD : G_WR);
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    tick();

    // ---------------- reset mid-write ----------------
    wr_req = 1'b1;
    exp_q.push_back(G_WR);
    await_grant("wr before reset", 4, 1, g);
    chk("pre-reset cmd", sdram_cmd, C_WR);
    #3 s_rst_n = 1'b0;
    #1;
    chk("async rst cmd",   sdram_cmd, NOP);
    chk("async rst dq_oe", dq_oe, 1'b0);
    chk("async rst addr",  sdram_addr, 0);
    chk("async rst en",    {ref_en, wr_en, rd_en}, 3'b000);
    wr_req = 1'b0;
    tick();
    s_rst_n = 1'b1;
    #1;
    chk("back in INIT", sdram_cmd, C_INIT);
    flag_init_end = 1'b1;
    tick();
    chk("idle after re-init", sdram_cmd, NOP);
    chk("scoreboard drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_sdram_arbit
`default_nettype wire
